lsq_dispatch_alloc: RTL and testbench

// - Dispatch-stage LDQ/STQ allocator. It assigns LDQ/STQ indices to up to DISPATCH_WIDTH memory ops per cycle.
// - For each dispatched store it drives the write port of the STQ following-load RAM:

---
 rtl/lsq_pkg.sv | 20 ++
 rtl/lsq_prefix_count.sv | 24 ++
 rtl/lsq_dispatch_alloc.sv | 125 ++++++++++++
 tb/tb_lsq_dispatch_alloc.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared types and sizing for the load/store queue dispatch allocator.
// Queue depths are powers of two so index arithmetic wraps by truncation.
package lsq_pkg;

    localparam int DISPATCH_WIDTH     = 4;
    localparam int LDQ_DEPTH          = 16;
    localparam int LDQ_INDEX          = 4;
    localparam int STQ_DEPTH          = 16;
    localparam int STQ_INDEX          = 4;
    localparam int COMMIT_WIDTH       = 4;
    localparam int DISPATCH_WIDTH_LOG = $clog2(DISPATCH_WIDTH);
    localparam int LANE_CNT_W         = DISPATCH_WIDTH_LOG + 1;
    localparam int COMMIT_CNT_W       = $clog2(COMMIT_WIDTH) + 1;

    typedef logic [LDQ_INDEX-1:0] ldq_idx_t;
    typedef logic [STQ_INDEX-1:0] stq_idx_t;
    typedef logic [LDQ_INDEX:0]   ldq_cnt_t;
    typedef logic [STQ_INDEX:0]   stq_cnt_t;

endpackage

// File: rtl/lsq_prefix_count.sv
// Exclusive prefix popcount over N lane flags, plus the total.
// prefix[i] counts set flags in lanes strictly below i.
module lsq_prefix_count #(
    parameter int N = 4,
    parameter int W = $clog2(N) + 1
) (
    input  logic [N-1:0]        flags,
    output logic [N-1:0][W-1:0] prefix,
    output logic [W-1:0]        total
);

    logic [W-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = acc;
            acc       = acc + W'(flags[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/lsq_dispatch_alloc.sv
// Dispatch-stage LDQ/STQ allocator: hands out queue indices per lane and
// writes each store's following-load index into the STQ side RAM.
module lsq_dispatch_alloc
    import lsq_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     dispatchValid_i,
    input  logic [DISPATCH_WIDTH-1:0]                laneValid_i,
    input  logic [DISPATCH_WIDTH-1:0]                isLoad_i,
    input  logic [DISPATCH_WIDTH-1:0]                isStore_i,
    input  logic [COMMIT_CNT_W-1:0]                  ldqCommitCnt_i,
    input  logic [COMMIT_CNT_W-1:0]                  stqCommitCnt_i,
    input  logic                                     flush_i,
    output logic                                     dispatchReady_o,
    output logic [DISPATCH_WIDTH-1:0][LDQ_INDEX-1:0] ldqIdx_o,
    output logic [DISPATCH_WIDTH-1:0][STQ_INDEX-1:0] stqIdx_o,
    output logic [DISPATCH_WIDTH-1:0]                fldWe_o,
    output logic [DISPATCH_WIDTH-1:0][STQ_INDEX-1:0] fldAddr_o,
    output logic [DISPATCH_WIDTH-1:0][LDQ_INDEX-1:0] fldData_o,
    output logic [LDQ_INDEX:0]                       ldqCount_o,
    output logic [STQ_INDEX:0]                       stqCount_o
);

    ldq_idx_t ldqHead, ldqTail;
    ldq_cnt_t ldqCount;
    stq_idx_t stqHead, stqTail;
    stq_cnt_t stqCount;

    logic [DISPATCH_WIDTH-1:0] ld, st;
    logic [DISPATCH_WIDTH-1:0][LANE_CNT_W-1:0] ldPre, stPre;
    logic [LANE_CNT_W-1:0] nLd, nSt;

    logic [LDQ_INDEX+1:0] ldqNeed;
    logic [STQ_INDEX+1:0] stqNeed;
    logic                 ready, fire;
    ldq_cnt_t             ldqFree, ldqAdd;
    stq_cnt_t             stqFree, stqAdd;

    assign ld = laneValid_i & isLoad_i;
    assign st = laneValid_i & isStore_i;

    lsq_prefix_count #(.N(DISPATCH_WIDTH), .W(LANE_CNT_W)) u_ld_prefix (
        .flags  (ld),
        .prefix (ldPre),
        .total  (nLd)
    );

    lsq_prefix_count #(.N(DISPATCH_WIDTH), .W(LANE_CNT_W)) u_st_prefix (
        .flags  (st),
        .prefix (stPre),
        .total  (nSt)
    );

    // Registered counts only: frees from this cycle's commit are not credited.
    assign ldqNeed = (LDQ_INDEX+2)'(ldqCount) + (LDQ_INDEX+2)'(nLd);
    assign stqNeed = (STQ_INDEX+2)'(stqCount) + (STQ_INDEX+2)'(nSt);
    assign ready   = (ldqNeed <= (LDQ_INDEX+2)'(LDQ_DEPTH))
                   & (stqNeed <= (STQ_INDEX+2)'(STQ_DEPTH))
                   & ~flush_i & ~reset;
    assign fire    = dispatchValid_i & ready;

    assign dispatchReady_o = ready;
    assign ldqCount_o      = ldqCount;
    assign stqCount_o      = stqCount;

    always_comb begin
        ldqIdx_o  = '0;
        stqIdx_o  = '0;
        fldAddr_o = '0;
        fldData_o = '0;
        fldWe_o   = {DISPATCH_WIDTH{fire & ~flush_i & ~reset}} & st;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            ldqIdx_o[i]  = ldqTail + ldq_idx_t'(ldPre[i]);
            stqIdx_o[i]  = stqTail + stq_idx_t'(stPre[i]);
            fldAddr_o[i] = stqTail + stq_idx_t'(stPre[i]);
            fldData_o[i] = ldqTail + ldq_idx_t'(ldPre[i]);
        end
    end

    // Commit frees clamp at the current occupancy so counts never underflow.
    always_comb begin
        ldqFree = ldq_cnt_t'(ldqCommitCnt_i);
        stqFree = stq_cnt_t'(stqCommitCnt_i);
        if (ldqFree > ldqCount) ldqFree = ldqCount;
        if (stqFree > stqCount) stqFree = stqCount;
        ldqAdd = fire ? ldq_cnt_t'(nLd) : '0;
        stqAdd = fire ? stq_cnt_t'(nSt) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ldqHead  <= '0;
            ldqTail  <= '0;
            ldqCount <= '0;
            stqHead  <= '0;
            stqTail  <= '0;
            stqCount <= '0;
        end else if (flush_i) begin
            ldqHead  <= ldqHead + ldq_idx_t'(ldqFree);
            ldqTail  <= ldqHead + ldq_idx_t'(ldqFree);
            ldqCount <= '0;
            stqHead  <= stqHead + stq_idx_t'(stqFree);
            stqTail  <= stqHead + stq_idx_t'(stqFree);
            stqCount <= '0;
        end else begin
            ldqHead  <= ldqHead + ldq_idx_t'(ldqFree);
            ldqTail  <= ldqTail + ldq_idx_t'(ldqAdd);
            ldqCount <= ldqCount - ldqFree + ldqAdd;
            stqHead  <= stqHead + stq_idx_t'(stqFree);
            stqTail  <= stqTail + stq_idx_t'(stqAdd);
            stqCount <= stqCount - stqFree + stqAdd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (ldq_cnt_t'(ldqCommitCnt_i) <= ldqCount);
            assert (stq_cnt_t'(stqCommitCnt_i) <= stqCount);
            if (dispatchValid_i)
                assert ((laneValid_i & isLoad_i & isStore_i) == '0);
        end
    end

endmodule

// File: tb/tb_lsq_dispatch_alloc.sv
// Directed bench for the LDQ/STQ dispatch allocator.
// Each task drives one scenario and compares against hand-computed values.
module tb_lsq_dispatch_alloc;

    logic             clk;
    logic             reset;
    logic             dispatchValid_i;
    logic [3:0]       laneValid_i;
    logic [3:0]       isLoad_i;
    logic [3:0]       isStore_i;
    logic [2:0]       ldqCommitCnt_i;
    logic [2:0]       stqCommitCnt_i;
    logic             flush_i;
    logic             dispatchReady_o;
    logic [3:0][3:0]  ldqIdx_o;
    logic [3:0][3:0]  stqIdx_o;
    logic [3:0]       fldWe_o;
    logic [3:0][3:0]  fldAddr_o;
    logic [3:0][3:0]  fldData_o;
    logic [4:0]       ldqCount_o;
    logic [4:0]       stqCount_o;

    int passed = 0;
    int total  = 0;

    lsq_dispatch_alloc dut (
        .clk             (clk),
        .reset           (reset),
        .dispatchValid_i (dispatchValid_i),
        .laneValid_i     (laneValid_i),
        .isLoad_i        (isLoad_i),
        .isStore_i       (isStore_i),
        .ldqCommitCnt_i  (ldqCommitCnt_i),
        .stqCommitCnt_i  (stqCommitCnt_i),
        .flush_i         (flush_i),
        .dispatchReady_o (dispatchReady_o),
        .ldqIdx_o        (ldqIdx_o),
        .stqIdx_o        (stqIdx_o),
        .fldWe_o         (fldWe_o),
        .fldAddr_o       (fldAddr_o),
        .fldData_o       (fldData_o),
        .ldqCount_o      (ldqCount_o),
        .stqCount_o      (stqCount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] lv,
                         input logic [3:0] ldm, input logic [3:0] stm,
                         input logic [2:0] lc, input logic [2:0] sc,
                         input logic fl);
        dispatchValid_i = v;
        laneValid_i     = lv;
        isLoad_i        = ldm;
        isStore_i       = stm;
        ldqCommitCnt_i  = lc;
        stqCommitCnt_i  = sc;
        flush_i         = fl;
    endtask

    task automatic idle();
        drive(1'b0, 4'b0, 4'b0, 4'b0, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 4'b1111, 4'b1010, 4'b0101, 3'd0, 3'd0, 1'b0);
        #1;
        total++;
        if (dispatchReady_o !== 1'b0)
            $display("FAIL reset_ready got %0b want 0", dispatchReady_o);
        else passed++;
        total++;
        if (fldWe_o !== 4'b0000)
            $display("FAIL reset_we got %b want 0000", fldWe_o);
        else passed++;
        step();
        step();
        total++;
        if (ldqCount_o !== 5'd0 || stqCount_o !== 5'd0)
            $display("FAIL reset_counts got %0d/%0d want 0/0", ldqCount_o, stqCount_o);
        else passed++;
        total++;
        if (ldqIdx_o[0] !== 4'd0 || stqIdx_o[0] !== 4'd0)
            $display("FAIL reset_tails got %0d/%0d want 0/0", ldqIdx_o[0], stqIdx_o[0]);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        drive(1'b1, 4'b1111, 4'b1010, 4'b0101, 3'd0, 3'd0, 1'b0);
        #1;
        total++;
        if (dispatchReady_o !== 1'b1)
            $display("FAIL basic_ready got %0b want 1", dispatchReady_o);
        else passed++;
        total++;
        if (stqIdx_o[0] !== 4'd0 || stqIdx_o[2] !== 4'd1)
            $display("FAIL basic_stqidx got %0d,%0d want 0,1", stqIdx_o[0], stqIdx_o[2]);
        else passed++;
        total++;
        if (ldqIdx_o[1] !== 4'd0 || ldqIdx_o[3] !== 4'd1)
            $display("FAIL basic_ldqidx got %0d,%0d want 0,1", ldqIdx_o[1], ldqIdx_o[3]);
        else passed++;
        total++;
        if (fldWe_o !== 4'b0101)
            $display("FAIL basic_we got %b want 0101", fldWe_o);
        else passed++;
        total++;
        if (fldData_o[0] !== 4'd0 || fldData_o[2] !== 4'd1)
            $display("FAIL basic_flddata got %0d,%0d want 0,1", fldData_o[0], fldData_o[2]);
        else passed++;
        total++;
        if (fldAddr_o[0] !== 4'd0 || fldAddr_o[2] !== 4'd1)
            $display("FAIL basic_fldaddr got %0d,%0d want 0,1", fldAddr_o[0], fldAddr_o[2]);
        else passed++;
        step();
        idle();
        #1;
        total++;
        if (ldqCount_o !== 5'd2 || stqCount_o !== 5'd2)
            $display("FAIL basic_counts got %0d/%0d want 2/2", ldqCount_o, stqCount_o);
        else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'b1111, 4'b0101, 4'b1010, 3'd0, 3'd0, 1'b0);
            step();
        end
        drive(1'b1, 4'b0011, 4'b0001, 4'b0010, 3'd0, 3'd0, 1'b0);
        step();
        drive(1'b0, 4'b0, 4'b0, 4'b0, 3'd1, 3'd1, 1'b0);
        step();
        idle();
        #1;
        total++;
        if (ldqCount_o !== 5'd14 || stqCount_o !== 5'd14)
            $display("FAIL wrap_pre_counts got %0d/%0d want 14/14", ldqCount_o, stqCount_o);
        else passed++;
        drive(1'b1, 4'b0111, 4'b0010, 4'b0101, 3'd0, 3'd0, 1'b0);
        #1;
        total++;
        if (stqIdx_o[0] !== 4'd15 || stqIdx_o[2] !== 4'd0)
            $display("FAIL wrap_stqidx got %0d,%0d want 15,0", stqIdx_o[0], stqIdx_o[2]);
        else passed++;
        total++;
        if (ldqIdx_o[1] !== 4'd15)
            $display("FAIL wrap_ldqidx got %0d want 15", ldqIdx_o[1]);
        else passed++;
        total++;
        if (fldData_o[0] !== 4'd15 || fldData_o[2] !== 4'd0)
            $display("FAIL wrap_flddata got %0d,%0d want 15,0", fldData_o[0], fldData_o[2]);
        else passed++;
        total++;
        if (fldWe_o !== 4'b0101 || dispatchReady_o !== 1'b1)
            $display("FAIL wrap_we got %b/%0b want 0101/1", fldWe_o, dispatchReady_o);
        else passed++;
        step();
        idle();
        #1;
        total++;
        if (ldqCount_o !== 5'd15 || stqCount_o !== 5'd16)
            $display("FAIL wrap_post_counts got %0d/%0d want 15/16", ldqCount_o, stqCount_o);
        else passed++;
        drive(1'b1, 4'b0001, 4'b0000, 4'b0001, 3'd0, 3'd0, 1'b0);
        #1;
        total++;
        if (dispatchReady_o !== 1'b0 || fldWe_o !== 4'b0000)
            $display("FAIL wrap_full_ready got %0b/%b want 0/0000", dispatchReady_o, fldWe_o);
        else passed++;
        step();
    endtask

    task automatic test_full();
        drive(1'b0, 4'b0, 4'b0, 4'b0, 3'd0, 3'd1, 1'b0);
        step();
        drive(1'b1, 4'b0011, 4'b0000, 4'b0011, 3'd0, 3'd0, 1'b0);
        #1;
        total++;
        if (dispatchReady_o !== 1'b0 || fldWe_o !== 4'b0000)
            $display("FAIL full_block got %0b/%b want 0/0000", dispatchReady_o, fldWe_o);
        else passed++;
        step();
        total++;
        if (stqCount_o !== 5'd15 || stqIdx_o[0] !== 4'd1)
            $display("FAIL full_hold got %0d/%0d want 15/1", stqCount_o, stqIdx_o[0]);
        else passed++;
        drive(1'b1, 4'b0011, 4'b0000, 4'b0011, 3'd0, 3'd1, 1'b0);
        #1;
        total++;
        if (dispatchReady_o !== 1'b0)
            $display("FAIL full_commit_same got %0b want 0", dispatchReady_o);
        else passed++;
        step();
        drive(1'b1, 4'b0011, 4'b0000, 4'b0011, 3'd0, 3'd0, 1'b0);
        #1;
        total++;
        if (dispatchReady_o !== 1'b1 || stqCount_o !== 5'd14)
            $display("FAIL full_commit_next got %0b/%0d want 1/14", dispatchReady_o, stqCount_o);
        else passed++;
        idle();
        step();
    endtask

    task automatic test_flush();
        drive(1'b1, 4'b1111, 4'b0101, 4'b1010, 3'd2, 3'd1, 1'b1);
        #1;
        total++;
        if (dispatchReady_o !== 1'b0 || fldWe_o !== 4'b0000)
            $display("FAIL flush_block got %0b/%b want 0/0000", dispatchReady_o, fldWe_o);
        else passed++;
        step();
        idle();
        #1;
        total++;
        if (ldqCount_o !== 5'd0 || stqCount_o !== 5'd0)
            $display("FAIL flush_counts got %0d/%0d want 0/0", ldqCount_o, stqCount_o);
        else passed++;
        total++;
        if (ldqIdx_o[0] !== 4'd3 || stqIdx_o[0] !== 4'd4)
            $display("FAIL flush_tails got %0d/%0d want 3/4", ldqIdx_o[0], stqIdx_o[0]);
        else passed++;
    endtask

    task automatic test_commit_dispatch();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b1111, 4'b1111, 4'b0000, 3'd0, 3'd0, 1'b0);
            step();
        end
        idle();
        #1;
        total++;
        if (ldqCount_o !== 5'd8 || ldqIdx_o[0] !== 4'd11)
            $display("FAIL cd_pre got %0d/%0d want 8/11", ldqCount_o, ldqIdx_o[0]);
        else passed++;
        drive(1'b1, 4'b0111, 4'b0111, 4'b0000, 3'd2, 3'd0, 1'b0);
        #1;
        total++;
        if (ldqIdx_o[2] !== 4'd13 || dispatchReady_o !== 1'b1)
            $display("FAIL cd_idx got %0d/%0b want 13/1", ldqIdx_o[2], dispatchReady_o);
        else passed++;
        step();
        idle();
        #1;
        total++;
        if (ldqCount_o !== 5'd9 || ldqIdx_o[0] !== 4'd14)
            $display("FAIL cd_post got %0d/%0d want 9/14", ldqCount_o, ldqIdx_o[0]);
        else passed++;
        drive(1'b0, 4'b0, 4'b0, 4'b0, 3'd0, 3'd0, 1'b1);
        step();
        idle();
        #1;
        total++;
        if (ldqIdx_o[0] !== 4'd5 || ldqCount_o !== 5'd0)
            $display("FAIL cd_head got %0d/%0d want 5/0", ldqIdx_o[0], ldqCount_o);
        else passed++;
    endtask

    task automatic test_sparse();
        drive(1'b1, 4'b1010, 4'b0011, 4'b1000, 3'd0, 3'd0, 1'b0);
        #1;
        total++;
        if (ldqIdx_o[1] !== 4'd5 || stqIdx_o[3] !== 4'd4)
            $display("FAIL sparse_idx got %0d/%0d want 5/4", ldqIdx_o[1], stqIdx_o[3]);
        else passed++;
        total++;
        if (fldData_o[3] !== 4'd6 || fldAddr_o[3] !== 4'd4)
            $display("FAIL sparse_fld got %0d/%0d want 6/4", fldData_o[3], fldAddr_o[3]);
        else passed++;
        total++;
        if (fldWe_o !== 4'b1000)
            $display("FAIL sparse_we got %b want 1000", fldWe_o);
        else passed++;
        step();
        idle();
        #1;
        total++;
        if (ldqCount_o !== 5'd1 || stqCount_o !== 5'd1)
            $display("FAIL sparse_counts got %0d/%0d want 1/1", ldqCount_o, stqCount_o);
        else passed++;
        total++;
        if (ldqIdx_o[0] !== 4'd6 || stqIdx_o[0] !== 4'd5)
            $display("FAIL sparse_tails got %0d/%0d want 6/5", ldqIdx_o[0], stqIdx_o[0]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'b1111, 4'b0101, 4'b1010, 3'd0, 3'd0, 1'b0);
        reset = 1'b1;
        #1;
        total++;
        if (dispatchReady_o !== 1'b0 || fldWe_o !== 4'b0000)
            $display("FAIL rstmid_block got %0b/%b want 0/0000", dispatchReady_o, fldWe_o);
        else passed++;
        step();
        reset = 1'b0;
        idle();
        #1;
        total++;
        if (ldqCount_o !== 5'd0 || stqCount_o !== 5'd0 || ldqIdx_o[0] !== 4'd0)
            $display("FAIL rstmid_state got %0d/%0d/%0d want 0/0/0",
                     ldqCount_o, stqCount_o, ldqIdx_o[0]);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_flush();
        test_commit_dispatch();
        test_sparse();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
